// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation encoding and controller states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OpMul = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpXor = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// ALU_SEQ_EARLY_TERM_EN: finish once the remaining multiplier bits are all zero.
module mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   sum;
  logic                 last;

  // product is the accumulator after the current iteration, valid while done=1
  assign sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = sum;

`ifdef ALU_SEQ_EARLY_TERM_EN
  assign last = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CntW'(WIDTH - 1));
`else
  assign last = (cnt_q == CntW'(WIDTH - 1));
`endif

  assign done = busy_q & last;

  always_comb begin
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      busy_d   = 1'b1;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
    end else if (busy_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; MUL runs on the mul_seq engine.
// ALU_SEQ_EARLY_TERM_EN (in mul_seq) shortens MUL latency; results are unchanged.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               z,
  output logic               n,
  output logic               c,
  output logic               v
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  op_e                  op_in;
  logic                 accept;
  logic                 mul_start, mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH-1:0]     diff, alu_res;

  assign op_in     = op_e'(op);
  assign accept    = in_valid && (state_q == StIdle);
  assign mul_start = accept && (op_in == OpMul);
  assign diff      = a - b;

  always_comb begin
    unique case (op_in)
      OpSub:   alu_res = diff;
      OpAnd:   alu_res = a & b;
      OpXor:   alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_in == OpMul) begin
            state_d = StMul;
          end else begin
            state_d  = StDone;
            result_d = {{WIDTH{1'b0}}, alu_res};
            z_d      = (alu_res == '0);
            n_d      = alu_res[WIDTH-1];
            c_d      = (op_in == OpSub) && (a >= b);
            // signed overflow: operand signs differ and result sign differs from a
            v_d      = (op_in == OpSub) && (a[WIDTH-1] != b[WIDTH-1]) &&
                       (diff[WIDTH-1] != a[WIDTH-1]);
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d  = StDone;
          result_d = mul_product;
          z_d      = (mul_product == '0);
          n_d      = mul_product[2*WIDTH-1];
          c_d      = 1'b0;
          v_d      = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign z         = z_q;
  assign n         = n_q;
  assign c         = c_q;
  assign v         = v_q;

endmodule
